muldiv_unit: RTL

Iterative multiply/divide unit for the pipelined MIPS datapath, executing the MULT (alucontrol 4'b1000) and DIV (alucontrol 4'b1001) codes from the ALU decoder over multiple cycles instead of in one combinational ALU pass. Width is parametrised, signed and unsigned modes are supported, and results go to architectural HI/LO registers. Sits beside the ALU in the execute stage. The hazard unit stalls on `busy`, and the pipeline may cancel an operation with `flush`.

---
 rtl/muldiv_unit.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers for the execute stage.
// Shift-add multiply and restoring divide, one bit per cycle, WIDTH cycles per operation.
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNTW  = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   input  logic             flush,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   // state | meaning
   // IDLE  | waiting for start; MTHI/MTLO honoured
   // MUL   | shift-add multiply, one multiplier bit per edge
   // DIV   | restoring divide, one quotient bit per edge
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

   localparam logic [3:0] OP_MUL = 4'b1000;
   localparam logic [3:0] OP_DIV = 4'b1001;

   state_t state, state_nx;
   logic load, finish;

   logic [CNTW-1:0]    cnt;
   logic [WIDTH-1:0]   mag_a, mag_b, srca_q;
   logic               sign_a, sign_b;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH:0]     rem;

   logic [WIDTH-1:0]   a_mag_in, b_mag_in;
   logic               a_neg_in, b_neg_in;

   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_nx, prod_fix;
   logic [WIDTH:0]     div_shift, rem_nx;
   logic [WIDTH+1:0]   div_diff;
   logic               div_ge;
   logic [WIDTH-1:0]   dq_nx, quo_fix, rem_fix;

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      finish   = 1'b0;
      case (state)
         S_IDLE: begin
            if (start && !flush) begin
               if (op == OP_MUL) begin
                  state_nx = S_MUL;
                  load     = 1'b1;
               end else if (op == OP_DIV) begin
                  state_nx = S_DIV;
                  load     = 1'b1;
               end
            end
         end
         S_MUL, S_DIV: begin
            if (flush) begin
               state_nx = S_IDLE;
            end else if (cnt == '0) begin
               state_nx = S_IDLE;
               finish   = 1'b1;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign busy = (state != S_IDLE);

   assign a_neg_in = is_signed & srca[WIDTH-1];
   assign b_neg_in = is_signed & srcb[WIDTH-1];
   assign a_mag_in = a_neg_in ? -srca : srca;
   assign b_mag_in = b_neg_in ? -srcb : srcb;

   // Multiply: acc = {partial product, remaining multiplier bits}
   assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
   assign mul_nx   = {mul_sum, acc[WIDTH-1:1]};
   assign prod_fix = (sign_a ^ sign_b) ? -mul_nx : mul_nx;

   // Divide: acc[WIDTH-1:0] shifts dividend bits out and quotient bits in
   assign div_shift = {rem[WIDTH-1:0], acc[WIDTH-1]};
   assign div_diff  = {1'b0, div_shift} - {2'b00, mag_b};
   assign div_ge    = ~div_diff[WIDTH+1];
   assign rem_nx    = div_ge ? div_diff[WIDTH:0] : div_shift;
   assign dq_nx     = {acc[WIDTH-2:0], div_ge};
   assign quo_fix   = (sign_a ^ sign_b) ? -dq_nx : dq_nx;
   assign rem_fix   = sign_a ? -rem_nx[WIDTH-1:0] : rem_nx[WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         hi       <= '0;
         lo       <= '0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         cnt      <= '0;
         mag_a    <= '0;
         mag_b    <= '0;
         srca_q   <= '0;
         sign_a   <= 1'b0;
         sign_b   <= 1'b0;
         acc      <= '0;
         rem      <= '0;
      end else begin
         done     <= 1'b0;
         div_zero <= 1'b0;
         if (state == S_IDLE) begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
         end
         if (load) begin
            mag_a  <= a_mag_in;
            mag_b  <= b_mag_in;
            sign_a <= a_neg_in;
            sign_b <= b_neg_in;
            srca_q <= srca;
            cnt    <= CNTW'(WIDTH - 1);
            acc    <= {{WIDTH{1'b0}}, (op == OP_MUL) ? b_mag_in : a_mag_in};
            rem    <= '0;
         end else if (state == S_MUL && !flush) begin
            acc <= mul_nx;
            cnt <= cnt - 1'b1;
            if (finish) begin
               hi   <= prod_fix[2*WIDTH-1:WIDTH];
               lo   <= prod_fix[WIDTH-1:0];
               done <= 1'b1;
            end
         end else if (state == S_DIV && !flush) begin
            acc[WIDTH-1:0] <= dq_nx;
            rem            <= rem_nx;
            cnt            <= cnt - 1'b1;
            if (finish) begin
               done <= 1'b1;
               // Zero divisor returns all-ones quotient and the original dividend
               if (mag_b == '0) begin
                  lo       <= '1;
                  hi       <= srca_q;
                  div_zero <= 1'b1;
               end else begin
                  lo <= quo_fix;
                  hi <= rem_fix;
               end
            end
         end
      end
   end

endmodule
